// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Round-robin arbiter that shares the single write port of the async FIFO
// (wr_clk domain) among NUM_REQ requesters. A grant covers one burst: the
// owner keeps the port until it sends req_last or has written BURST_MAX
// beats. FIFO back-pressure (fifo_full) is passed straight to the owner, so
// beats are never lost or duplicated.
//
// Ports:
//   wr_clk          FIFO write clock
//   rst             asynchronous, active-high reset
//   req_valid       per-requester beat valid            [NUM_REQ]
//   req_data        per-requester beat, requester i at  [i*DATA_WIDTH +: DATA_WIDTH]
//   req_last        per-requester last-beat marker      [NUM_REQ]
//   req_ready       per-requester accept                [NUM_REQ]
//   fifo_full       FIFO full flag (registered in the FIFO)
//   fifo_wr_en      FIFO write enable
//   fifo_write_data FIFO write data
//   grant_id        current owner, meaningful while busy is high
//   busy            high while a requester holds the port
//   stall_count     (only with FIFO_WR_ARB_STALL_CNT_EN) saturating count of
//                   cycles the owner had a beat ready while the FIFO was full
//
// Optional feature macro: FIFO_WR_ARB_STALL_CNT_EN

module fifo_wr_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_REQ    = 4,
  parameter  int BURST_MAX  = 4,
  localparam int IW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW         = $clog2(BURST_MAX) + 1
) (
  input  logic                          wr_clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [15:0]                   stall_count
`endif
);

  typedef enum logic {
    ARB,
    GRANT
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [IW-1:0]   last_id_q, last_id_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            busy_q, busy_d;

  logic            any_valid;
  logic [IW-1:0]   win_id;
  logic [IW-1:0]   cand;
  int              idx;

  logic            in_grant;
  logic            own_valid;
  logic            own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic            burst_end;

  // Round-robin search. Offsets are walked from farthest to nearest so the
  // last match written is the first valid requester above last_id.
  always_comb begin
    any_valid = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = (int'(last_id_q) + k) % NUM_REQ;
      cand = IW'(idx);
      if (req_valid[cand]) begin
        any_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Select the owner's valid/last/data. Only grant_id feeds the select, so
  // req_data never reaches any control signal.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IW'(i)) begin
        own_valid = req_valid[i];
        own_last  = req_last[i];
        own_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Write-port outputs are combinational from state, owner valid and full.
  always_comb begin
    in_grant        = (state_q == GRANT);
    req_ready       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = in_grant && !fifo_full && (grant_id_q == IW'(i));
    end
    fifo_wr_en      = in_grant && own_valid && !fifo_full;
    fifo_write_data = in_grant ? own_data : '0;
    burst_end       = own_last || ((beat_cnt_q + CW'(1)) == CW'(BURST_MAX));
  end

  // Next-state logic. A stalled or idle owner simply holds everything.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    unique case (state_q)
      ARB: begin
        if (any_valid) begin
          state_d    = GRANT;
          grant_id_d = win_id;
          beat_cnt_d = '0;
          busy_d     = 1'b1;
        end
      end
      GRANT: begin
        if (fifo_wr_en) begin
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (burst_end) begin
            state_d   = ARB;
            last_id_d = grant_id_q;
            busy_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = ARB;
        busy_d  = 1'b0;
      end
    endcase
  end

  // last_id resets to the top requester so requester 0 wins first.
  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      grant_id_q <= '0;
      last_id_q  <= IW'(NUM_REQ - 1);
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  // Counts owner-ready-but-full cycles, saturating rather than wrapping.
  always_comb begin
    stall_d = stall_q;
    if (in_grant && own_valid && fifo_full && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge wr_clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, BURST_MAX=4, 8-bit
// beats). Each requester is a queue of pending beats; a burst-level reference
// model decides who owns the port and predicts every write-port output.
// Directed scenarios come first, then a randomized traffic phase.

module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BM = 4;
  localparam int IW = 2;

  logic              wr_clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic              fifo_full;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_write_data;
  logic [IW-1:0]     grant_id;
  logic              busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [15:0]       stall_count;
`endif

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .BURST_MAX  (BM)
  ) dut (
    .wr_clk          (wr_clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_last        (req_last),
    .req_ready       (req_ready),
    .fifo_full       (fifo_full),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_write_data (fifo_write_data),
    .grant_id        (grant_id),
    .busy            (busy)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    .stall_count     (stall_count)
`endif
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int errors = 0;
  int checks = 0;

  // Pending beats per requester: bit 8 is the last marker, bits 7:0 data.
  logic [8:0] rq [N][$];
  logic [N-1:0] vmask;
  logic         full_force;

  // Reference model: owner is -1 while arbitrating.
  int          m_owner;
  int          m_beats;
  int          m_last;
  logic [15:0] m_stall;

  logic          exp_wr;
  int            dut_writes;
  logic          prev_busy;
  logic [IW-1:0] grant_log [$];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_beats = 0;
    m_last  = N - 1;
    m_stall = '0;
  endtask

  task automatic pushBurst(input int r, input int len, input logic with_last);
    for (int b = 0; b < len; b++) begin
      logic [7:0] d;
      d = 8'($urandom);
      rq[r].push_back({(with_last && (b == len - 1)), d});
    end
  endtask

  // Drive requester heads and full flag on the falling edge.
  task automatic applyStimulus();
    @(negedge wr_clk);
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]           = !vmask[i];
        req_data[i*DW +: DW]   = rq[i][0][7:0];
        req_last[i]            = rq[i][0][8];
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = '0;
        req_last[i]            = 1'b0;
      end
    end
    fifo_full = full_force;
    #1;
  endtask

  // Compare the write-port outputs against the model's prediction.
  task automatic checkOutput();
    logic [N-1:0]  exp_ready;
    logic [DW-1:0] exp_data;
    exp_ready = '0;
    exp_data  = '0;
    exp_wr    = 1'b0;
    if (m_owner >= 0) begin
      exp_ready[m_owner] = !fifo_full;
      exp_wr             = req_valid[m_owner] && !fifo_full;
      exp_data           = req_data[m_owner*DW +: DW];
    end
    checkVal("busy", 32'(busy), 32'(m_owner >= 0));
    if (m_owner >= 0) checkVal("grant_id", 32'(grant_id), 32'(m_owner));
    checkVal("req_ready", 32'(req_ready), 32'(exp_ready));
    checkVal("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
    checkVal("fifo_write_data", 32'(fifo_write_data), 32'(exp_data));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    checkVal("stall_count", 32'(stall_count), 32'(m_stall));
`endif
    if (fifo_wr_en === 1'b1) dut_writes++;
    if (busy === 1'b1 && prev_busy !== 1'b1) grant_log.push_back(grant_id);
    prev_busy = busy;
  endtask

  // Advance the burst-level model across the rising edge.
  task automatic modelAdvance();
    logic was_last;
    @(posedge wr_clk);
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int r;
        r = (m_last + k) % N;
        if (m_owner < 0 && req_valid[r]) begin
          m_owner = r;
          m_beats = 0;
        end
      end
    end else begin
      if (req_valid[m_owner] && fifo_full && m_stall != 16'hFFFF) m_stall++;
      if (exp_wr) begin
        was_last = rq[m_owner][0][8];
        void'(rq[m_owner].pop_front());
        m_beats++;
        if (was_last || m_beats == BM) begin
          m_last  = m_owner;
          m_owner = -1;
        end
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) begin
      applyStimulus();
      checkOutput();
      modelAdvance();
    end
  endtask

  function automatic int pendingBeats();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  // Run until every queue is empty and the port is back in arbitration.
  task automatic drain(input string tag, input int budget);
    int c;
    c = 0;
    while ((pendingBeats() > 0 || m_owner >= 0) && c < budget) begin
      runCycles(1);
      c++;
    end
    checkVal({tag, "_drain_done"}, 32'(pendingBeats() == 0 && m_owner < 0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    rst        = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    fifo_full  = 1'b0;
    vmask      = '0;
    full_force = 1'b0;
    dut_writes = 0;
    prev_busy  = 1'b0;
    modelReset();

    // Reset values while rst is held.
    repeat (2) @(negedge wr_clk);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    checkVal("rst_ready", 32'(req_ready), 32'd0);
    checkVal("rst_data", 32'(fifo_write_data), 32'd0);
    checkVal("rst_grant_id", 32'(grant_id), 32'd0);
    rst = 1'b0;

    // Idle after reset: nothing granted, nothing written.
    w0 = dut_writes;
    runCycles(5);
    checkVal("idle_writes", 32'(dut_writes - w0), 32'd0);

    // All four requesters with 2-beat bursts: order 0,1,2,3, 8 writes in 12.
    $display("[TB] four 2-beat bursts");
    for (int i = 0; i < N; i++) pushBurst(i, 2, 1'b1);
    grant_log.delete();
    w0 = dut_writes;
    runCycles(12);
    checkVal("rr_writes_in_12", 32'(dut_writes - w0), 32'd8);
    checkVal("rr_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) checkVal("rr_grant_order", 32'(grant_log[i]), 32'(i));
    end
    drain("rr", 20);

    // Requester 1: 6 beats, no last. 4 beats, re-arbitrate, then 2 more.
    $display("[TB] BURST_MAX split");
    pushBurst(1, 6, 1'b0);
    grant_log.delete();
    w0 = dut_writes;
    runCycles(10);
    checkVal("split_writes", 32'(dut_writes - w0), 32'd6);
    checkVal("split_regrant", 32'(grant_log.size()), 32'd2);
    checkVal("split_hold_busy", 32'(busy), 32'd1);
    pushBurst(1, 1, 1'b1);
    drain("split", 10);

    // fifo_full for 3 cycles mid-burst on requester 2.
    $display("[TB] full stall mid-burst");
    pushBurst(2, 4, 1'b1);
    w0 = dut_writes;
    runCycles(3);
    full_force = 1'b1;
    runCycles(3);
    full_force = 1'b0;
    drain("stall", 10);
    checkVal("stall_writes", 32'(dut_writes - w0), 32'd4);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    checkVal("stall_count_total", 32'(stall_count), 32'd3);
`endif

    // Owner 0 drops valid for 2 cycles while requester 2 waits.
    $display("[TB] owner valid gap");
    pushBurst(0, 3, 1'b1);
    pushBurst(2, 2, 1'b1);
    runCycles(2);
    vmask[0] = 1'b1;
    runCycles(2);
    checkVal("gap_owner_held", 32'(grant_id), 32'd0);
    vmask[0] = 1'b0;
    drain("gap", 20);

    // Randomized traffic with random back-pressure.
    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() == 0 && $urandom_range(0, 7) == 0)
          pushBurst(i, int'($urandom_range(1, 7)), 1'b1);
      end
      full_force = ($urandom_range(0, 3) == 0);
      runCycles(1);
    end
    full_force = 1'b0;
    drain("rand", 400);

    // Reset pulsed mid-burst, then requester 0 wins first again.
    $display("[TB] reset mid-burst");
    for (int i = 0; i < N; i++) pushBurst(i, 4, 1'b1);
    runCycles(7);
    applyStimulus();
    rst = 1'b1;
    #1;
    checkVal("mid_rst_busy", 32'(busy), 32'd0);
    checkVal("mid_rst_wr_en", 32'(fifo_wr_en), 32'd0);
    checkVal("mid_rst_ready", 32'(req_ready), 32'd0);
    checkVal("mid_rst_data", 32'(fifo_write_data), 32'd0);
    modelReset();
    prev_busy = 1'b0;
    @(posedge wr_clk);
    #2;
    rst = 1'b0;
    grant_log.delete();
    runCycles(2);
    checkVal("post_rst_first", 32'(grant_log.size() > 0 ? grant_log[0] : 2'd3), 32'd0);
    drain("post_rst", 60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
